// File: rtl/osd_pkg.sv
// Shared definitions for the OSD SPI command receiver: opcodes, FSM states
// and the buffer-write bundle.
package osd_pkg;
  localparam int OSD_ADDR_W = 11;
  localparam int OSD_LINE_W = 3;

  // Opcodes are compared under a mask; don't-care bits carry the argument.
  localparam logic [7:0] OSD_CMD_WRITE      = 8'b0010_0000;
  localparam logic [7:0] OSD_CMD_WRITE_MSK  = 8'b1111_1000;
  localparam logic [7:0] OSD_CMD_ENABLE     = 8'b0100_0000;
  localparam logic [7:0] OSD_CMD_ENABLE_MSK = 8'b1111_1110;

  typedef enum logic [1:0] {IDLE, CMD, WRITE, IGNORE} osd_rx_state_t;

  typedef struct packed {
    logic                  we;
    logic [OSD_ADDR_W-1:0] addr;
    logic [7:0]            data;
  } osd_wr_t;

  function automatic logic cmd_match(input logic [7:0] b, input logic [7:0] op,
                                     input logic [7:0] msk);
    return (b & msk) == op;
  endfunction
endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous 1-bit input, with a third flop
// giving single-cycle rise/fall pulses in the clk_pix domain.
module sync_edge (
  input  logic clk_pix,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [2:0] s;

  always_ff @(posedge clk_pix) begin
    if (!reset_n) s <= '0;
    else          s <= {s[1:0], d};
  end

  assign q    = s[1];
  assign rise =  s[1] & ~s[2];
  assign fall = ~s[1] &  s[2];
endmodule

// File: rtl/osd_spi_rx.sv
// Oversampled SPI slave turning OSD commands into character-buffer write
// strobes and the OSD enable flag.
module osd_spi_rx
  import osd_pkg::*;
#(
  parameter int LINES      = 8,
  parameter int LINE_BYTES = 256
) (
  input  logic                  clk_pix,
  input  logic                  reset_n,
  input  logic                  SPI_SCK,
  input  logic                  SPI_SS3,
  input  logic                  SPI_DI,
  output logic                  buf_we,
  output logic [OSD_ADDR_W-1:0] buf_addr,
  output logic [7:0]            buf_data,
  output logic                  osd_enable
);
  localparam int LW = $clog2(LINES);
  localparam int CW = $clog2(LINE_BYTES);
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_BYTES - 1);

  logic       sck_q, sck_rise, sck_fall;
  logic       ss_s, ss_rise, ss_fall;
  logic [1:0] di_s;

  sync_edge u_sck (.clk_pix, .reset_n, .d(SPI_SCK), .q(sck_q), .rise(sck_rise), .fall(sck_fall));
  sync_edge u_ss  (.clk_pix, .reset_n, .d(SPI_SS3), .q(ss_s),  .rise(ss_rise),  .fall(ss_fall));

  logic unused_ok;
  assign unused_ok = &{1'b0, sck_q, sck_fall, ss_rise, ss_fall};

  always_ff @(posedge clk_pix) begin
    if (!reset_n) di_s <= '0;
    else          di_s <= {di_s[0], SPI_DI};
  end

  // Edge-detect stage: SS and DI travel alongside the SCK rise so the FSM
  // always sees all three time-aligned.
  logic rise_q, di_q, ss_q;
  always_ff @(posedge clk_pix) begin
    if (!reset_n) begin
      rise_q <= 1'b0;
      di_q   <= 1'b0;
      ss_q   <= 1'b0;
    end else begin
      rise_q <= sck_rise;
      di_q   <= di_s[1];
      ss_q   <= ss_s;
    end
  end

  // Byte assembly; SS high clears the bit counter, dropping any partial byte.
  logic [7:0] sr;
  logic [2:0] bit_cnt;
  logic       byte_done, ss_d;
  always_ff @(posedge clk_pix) begin
    if (!reset_n) begin
      sr        <= '0;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
      ss_d      <= 1'b0;
    end else begin
      ss_d      <= ss_q;
      byte_done <= rise_q & ~ss_q & (bit_cnt == 3'd7);
      if (ss_q) bit_cnt <= '0;
      else if (rise_q) begin
        bit_cnt <= bit_cnt + 3'd1;
        sr      <= {sr[6:0], di_q};
      end
    end
  end

  osd_rx_state_t state, state_nx;
  osd_wr_t       wr, wr_nx;
  logic          en, en_nx;
  logic [LW-1:0] line, line_nx;
  logic [CW-1:0] col, col_nx;

  // Reset lands in IGNORE so a frame cut by reset is never reinterpreted;
  // the first SS-high cycle returns to IDLE.
  always_ff @(posedge clk_pix) begin
    if (!reset_n) begin
      state <= IGNORE;
      wr    <= '0;
      en    <= 1'b0;
      line  <= '0;
      col   <= '0;
    end else begin
      state <= state_nx;
      wr    <= wr_nx;
      en    <= en_nx;
      line  <= line_nx;
      col   <= col_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    wr_nx      = wr;
    wr_nx.we   = 1'b0;
    en_nx      = en;
    line_nx    = line;
    col_nx     = col;
    if (ss_d) state_nx = IDLE;
    else begin
      unique case (state)
        IDLE: state_nx = CMD;
        CMD: if (byte_done) begin
          state_nx = IGNORE;
          if (cmd_match(sr, OSD_CMD_WRITE, OSD_CMD_WRITE_MSK)) begin
            line_nx  = sr[LW-1:0];
            col_nx   = '0;
            state_nx = WRITE;
          end else if (cmd_match(sr, OSD_CMD_ENABLE, OSD_CMD_ENABLE_MSK)) begin
            en_nx = sr[0];
          end
        end
        WRITE: if (byte_done) begin
          wr_nx.we   = 1'b1;
          wr_nx.addr = {line, col};
          wr_nx.data = sr;
          col_nx     = col + 1'b1;
          if (col == COL_LAST) state_nx = IGNORE;
        end
        IGNORE: state_nx = IGNORE;
        default: state_nx = IGNORE;
      endcase
    end
  end

  assign buf_we     = wr.we;
  assign buf_addr   = wr.addr;
  assign buf_data   = wr.data;
  assign osd_enable = en;
endmodule

// File: tb/tb_osd_spi_rx.sv
// Directed + randomized bench for osd_spi_rx with a frame-level reference model.
module tb_osd_spi_rx;
  logic        clk_pix = 1'b0;
  logic        reset_n = 1'b0;
  logic        SPI_SCK = 1'b0;
  logic        SPI_SS3 = 1'b1;
  logic        SPI_DI  = 1'b0;
  logic        buf_we;
  logic [10:0] buf_addr;
  logic [7:0]  buf_data;
  logic        osd_enable;

  osd_spi_rx dut (
    .clk_pix(clk_pix), .reset_n(reset_n), .SPI_SCK(SPI_SCK), .SPI_SS3(SPI_SS3),
    .SPI_DI(SPI_DI), .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data),
    .osd_enable(osd_enable)
  );

  always #5 clk_pix = ~clk_pix;

  int cyc = 0;
  always @(posedge clk_pix) cyc++;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;
  exp_t       exp_q[$];
  exp_t       e;
  logic [7:0] fb[$];
  bit         m_en = 1'b0;
  logic       prev_we = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Every strobe must match the oldest expected write, including its cycle.
  always @(negedge clk_pix) begin
    if (buf_we === 1'b1) begin
      chk("we_single_cycle", {31'd0, prev_we}, 0);
      chk("we_expected", {31'd0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", {21'd0, buf_addr}, e.addr);
        chk("wr_data", {24'd0, buf_data}, e.data);
        chk("wr_latency", cyc, e.cyc);
      end
    end
    prev_we = buf_we;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_pix);
  endtask

  // Mode 0, MSB first, 3 clk_pix low + 3 high per bit.
  task automatic send_bits(input logic [7:0] b, input int nbits, input bit push, input int addr);
    for (int i = 0; i < nbits; i++) begin
      SPI_SCK = 1'b0;
      SPI_DI  = b[7-i];
      tick(3);
      SPI_SCK = 1'b1;
      if (i == 7 && push) exp_q.push_back('{addr: addr, data: int'(b), cyc: cyc + 5});
      tick(3);
    end
    SPI_SCK = 1'b0;
  endtask

  // Model: byte 0 is the command; 0x20..0x27 writes bytes 1..256 to that
  // line, 0x40/0x41 sets enable, anything else is ignored. A reset after
  // byte reset_at kills the rest of the frame.
  task automatic send_frame(input int tail_bits, input int reset_at);
    bit is_wr, is_en, wr;
    int line;
    is_wr = fb[0] >= 8'h20 && fb[0] <= 8'h27;
    is_en = fb[0] == 8'h40 || fb[0] == 8'h41;
    line  = int'(fb[0]) - 32;
    SPI_SS3 = 1'b0;
    tick(3);
    for (int i = 0; i < fb.size(); i++) begin
      wr = is_wr && i >= 1 && i <= 256 && (reset_at < 0 || i <= reset_at);
      send_bits(fb[i], 8, wr, line * 256 + i - 1);
      if (i == 0 && is_en) m_en = fb[0][0];
      if (i == reset_at) begin
        tick(4);
        reset_n = 1'b0;
        tick(2);
        chk("rst_mid_we", {31'd0, buf_we}, 0);
        chk("rst_mid_addr", {21'd0, buf_addr}, 0);
        chk("rst_mid_data", {24'd0, buf_data}, 0);
        chk("rst_mid_en", {31'd0, osd_enable}, 0);
        reset_n = 1'b1;
        m_en = 1'b0;
        tick(2);
      end
    end
    if (tail_bits > 0) send_bits(8'($urandom), tail_bits, 1'b0, 0);
    tick(3);
    SPI_SS3 = 1'b1;
    tick(8);
    chk("frame_drain", exp_q.size(), 0);
    chk("osd_enable", {31'd0, osd_enable}, {31'd0, m_en});
  endtask

  initial begin
    // Reset with SPI pins wiggling
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      SPI_SCK = 1'($urandom);
      SPI_DI  = 1'($urandom);
      SPI_SS3 = 1'($urandom);
      tick(1);
      chk("rst_we", {31'd0, buf_we}, 0);
    end
    SPI_SCK = 1'b0;
    SPI_SS3 = 1'b1;
    reset_n = 1'b1;
    tick(6);
    chk("rst_we_after", {31'd0, buf_we}, 0);
    chk("rst_addr", {21'd0, buf_addr}, 0);
    chk("rst_data", {24'd0, buf_data}, 0);
    chk("rst_en", {31'd0, osd_enable}, 0);

    // Line write to line 3
    fb = '{8'h23, 8'h41, 8'h42};
    send_frame(0, -1);

    // Enable on, trailing bytes ignored; then disable
    fb = '{8'h41, 8'hAA, 8'h55};
    send_frame(0, -1);
    fb = '{8'h40};
    send_frame(0, -1);

    // Overflow past the end of line 7
    fb = {};
    fb.push_back(8'h27);
    for (int i = 0; i < 258; i++) fb.push_back(8'($urandom));
    send_frame(0, -1);

    // Aborted partial byte, then a fresh command frame
    fb = '{8'h20, 8'h00};
    fb[1] = 8'($urandom);
    send_frame(5, -1);
    fb = '{8'h23, 8'h11};
    send_frame(0, -1);

    // Unknown command
    fb = '{8'h99, 8'h21, 8'h41, 8'h27};
    send_frame(0, -1);

    // Reset in the middle of a line write, with enable set beforehand
    fb = '{8'h41};
    send_frame(0, -1);
    fb = {};
    fb.push_back(8'h20 + 8'($urandom_range(0, 7)));
    for (int i = 0; i < 13; i++) fb.push_back(8'($urandom));
    send_frame(0, 10);
    fb = {};
    fb.push_back(8'h25);
    for (int i = 0; i < 2; i++) fb.push_back(8'($urandom));
    send_frame(0, -1);

    // Random frames
    for (int f = 0; f < 8; f++) begin
      fb = {};
      case ($urandom_range(0, 2))
        0: fb.push_back(8'h20 + 8'($urandom_range(0, 7)));
        1: fb.push_back(8'h40 + 8'($urandom_range(0, 1)));
        default: fb.push_back(8'($urandom));
      endcase
      for (int i = 0; i < int'($urandom_range(0, 6)); i++) fb.push_back(8'($urandom));
      send_frame(int'($urandom_range(0, 1)) * int'($urandom_range(1, 7)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
